// File: rtl/load_store_unit.sv
// Load/store unit: steers store lanes/strobes and extends load data on a word-addressed bus.
// Latency: 3 cycles minimum (IDLE accept, BUS with ready, DONE pulse); one access in flight.
// Backpressure: stalls the core while the bus withholds ready, aborting with a fault after TIMEOUT cycles.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_req,
    input  logic              I_memrw,
    input  logic [2:0]        I_loadsel,
    input  logic [1:0]        I_storesel,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic [31:0]       I_wdata,
    output logic              O_stall,
    output logic [31:0]       O_rdata,
    output logic              O_done,
    output logic              O_misaligned,
    output logic              O_fault,
    output logic              O_bus_valid,
    output logic              O_bus_we,
    output logic [ADDR_W-1:0] O_bus_addr,
    output logic [3:0]        O_bus_wstrb,
    output logic [31:0]       O_bus_wdata,
    input  logic              I_bus_ready,
    input  logic [31:0]       I_bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ld_sel_q;
    logic [1:0]       off_q;
    logic             mis;
    logic             accept;
    logic [31:0]      st_wdata;
    logic [3:0]       st_strb;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      ld_ext;

    // Reserved select codes fall into the default arms and are rejected as misaligned.
    always_comb begin
        mis = 1'b0;
        if (I_memrw) begin
            case (I_storesel)
                2'b00:   mis = 1'b0;
                2'b01:   mis = I_addr[0];
                2'b10:   mis = |I_addr[1:0];
                default: mis = 1'b1;
            endcase
        end else begin
            case (I_loadsel)
                3'b000, 3'b100: mis = 1'b0;
                3'b001, 3'b101: mis = I_addr[0];
                3'b010:         mis = |I_addr[1:0];
                default:        mis = 1'b1;
            endcase
        end
    end

    always_comb begin
        st_wdata = I_wdata;
        st_strb  = 4'b1111;
        case (I_storesel)
            2'b00: begin
                st_wdata = {4{I_wdata[7:0]}};
                st_strb  = 4'b0001 << I_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{I_wdata[15:0]}};
                st_strb  = 4'b0011 << I_addr[1:0];
            end
            default: begin
                st_wdata = I_wdata;
                st_strb  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        byte_v = I_bus_rdata[{off_q, 3'b000} +: 8];
        half_v = off_q[1] ? I_bus_rdata[31:16] : I_bus_rdata[15:0];
        case (ld_sel_q)
            3'b000:  ld_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  ld_ext = {{16{half_v[15]}}, half_v};
            3'b100:  ld_ext = {24'd0, byte_v};
            3'b101:  ld_ext = {16'd0, half_v};
            default: ld_ext = I_bus_rdata;
        endcase
    end

    assign accept       = (state == IDLE) && I_req && !mis;
    assign O_stall      = (state == BUS) || accept;
    assign O_misaligned = (state == IDLE) && I_req && mis;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ld_sel_q    <= 3'b000;
            off_q       <= 2'b00;
            O_rdata     <= 32'd0;
            O_done      <= 1'b0;
            O_fault     <= 1'b0;
            O_bus_valid <= 1'b0;
            O_bus_we    <= 1'b0;
            O_bus_addr  <= '0;
            O_bus_wstrb <= 4'b0000;
            O_bus_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    O_done  <= 1'b0;
                    O_fault <= 1'b0;
                    if (accept) begin
                        state       <= BUS;
                        cnt         <= '0;
                        ld_sel_q    <= I_loadsel;
                        off_q       <= I_addr[1:0];
                        O_bus_valid <= 1'b1;
                        O_bus_we    <= I_memrw;
                        O_bus_addr  <= {I_addr[ADDR_W-1:2], 2'b00};
                        O_bus_wstrb <= I_memrw ? st_strb : 4'b0000;
                        O_bus_wdata <= st_wdata;
                    end
                end
                BUS: begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    if (I_bus_ready) begin
                        O_bus_valid <= 1'b0;
                        O_done      <= 1'b1;
                        state       <= DONE;
                        if (!O_bus_we) O_rdata <= ld_ext;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        O_bus_valid <= 1'b0;
                        O_rdata     <= 32'd0;
                        O_fault     <= 1'b1;
                        O_done      <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    O_done  <= 1'b0;
                    O_fault <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table plus hand sequences for timeout and mid-access reset.
module tb_load_store_unit;
    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_req = 1'b0;
    logic        I_memrw = 1'b0;
    logic [2:0]  I_loadsel = 3'b000;
    logic [1:0]  I_storesel = 2'b00;
    logic [31:0] I_addr = 32'd0;
    logic [31:0] I_wdata = 32'd0;
    logic        I_bus_ready = 1'b0;
    logic [31:0] I_bus_rdata = 32'd0;
    logic        O_stall, O_done, O_misaligned, O_fault, O_bus_valid, O_bus_we;
    logic [31:0] O_rdata, O_bus_addr, O_bus_wdata;
    logic [3:0]  O_bus_wstrb;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_req(I_req), .I_memrw(I_memrw),
        .I_loadsel(I_loadsel), .I_storesel(I_storesel), .I_addr(I_addr),
        .I_wdata(I_wdata), .O_stall(O_stall), .O_rdata(O_rdata), .O_done(O_done),
        .O_misaligned(O_misaligned), .O_fault(O_fault), .O_bus_valid(O_bus_valid),
        .O_bus_we(O_bus_we), .O_bus_addr(O_bus_addr), .O_bus_wstrb(O_bus_wstrb),
        .O_bus_wdata(O_bus_wdata), .I_bus_ready(I_bus_ready), .I_bus_rdata(I_bus_rdata)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic        memrw;
        logic [2:0]  lsel;
        logic [1:0]  ssel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          waitc;
        logic        mis;
        logic [31:0] eaddr;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        logic [31:0] erdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = 32'd0;
    int          total = 0;
    int          bad = 0;
    vec_t        vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge I_clk) begin
        if (!I_rst && O_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_rdata", O_rdata, e.rdata);
                chk("done_fault", {31'd0, O_fault}, {31'd0, e.fault});
            end
        end
    end

    task automatic drive(input vec_t v);
        I_req      = 1'b1;
        I_memrw    = v.memrw;
        I_loadsel  = v.lsel;
        I_storesel = v.ssel;
        I_addr     = v.addr;
        I_wdata    = v.wdata;
    endtask

    task automatic push_exp(input logic memrw, input logic [31:0] rd, input logic fault);
        exp_t e;
        e.rdata = fault ? 32'd0 : (memrw ? model_rdata : rd);
        e.fault = fault;
        model_rdata = e.rdata;
        sb.push_back(e);
    endtask

    task automatic run_access(input vec_t v);
        int stalls;
        @(negedge I_clk);
        drive(v);
        I_bus_ready = 1'b0;
        #1;
        if (v.mis) begin
            chk("mis_pulse", {31'd0, O_misaligned}, 32'd1);
            chk("mis_stall", {31'd0, O_stall}, 32'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge I_clk);
                I_req = 1'b0;
                chk("mis_no_valid", {31'd0, O_bus_valid}, 32'd0);
            end
        end else begin
            chk("acc_stall", {31'd0, O_stall}, 32'd1);
            chk("acc_no_mis", {31'd0, O_misaligned}, 32'd0);
            stalls = O_stall ? 1 : 0;
            push_exp(v.memrw, v.erdata, 1'b0);
            for (int i = 1; i <= v.waitc; i++) begin
                @(negedge I_clk);
                I_req = 1'b0;
                chk("bus_valid", {31'd0, O_bus_valid}, 32'd1);
                chk("bus_we", {31'd0, O_bus_we}, {31'd0, v.memrw});
                chk("bus_addr", O_bus_addr, v.eaddr);
                chk("bus_wstrb", {28'd0, O_bus_wstrb}, {28'd0, v.estrb});
                if (v.memrw) chk("bus_wdata", O_bus_wdata, v.ewdata);
                if (O_stall) stalls++;
                if (i == v.waitc) begin
                    I_bus_ready = 1'b1;
                    I_bus_rdata = v.brd;
                end
            end
            @(negedge I_clk);
            I_bus_ready = 1'b0;
            chk("done_seen", {31'd0, O_done}, 32'd1);
            chk("done_stall", {31'd0, O_stall}, 32'd0);
            chk("stall_cycles", stalls, v.waitc + 1);
        end
    endtask

    initial begin
        int vcnt;
        bit seen;
        vecs[0]  = '{1'b0, 3'b010, 2'b00, 32'h100, 32'h0,        32'hDEADBEEF, 2, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b000, 2'b00, 32'h203, 32'h0,        32'h80123456, 1, 1'b0, 32'h200, 4'b0000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 2'b00, 32'h203, 32'h0,        32'h80123456, 3, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b0, 3'b001, 2'b00, 32'h202, 32'h0,        32'h8001ABCD, 1, 1'b0, 32'h200, 4'b0000, 32'h0,        32'hFFFF8001};
        vecs[4]  = '{1'b0, 3'b101, 2'b00, 32'h202, 32'h0,        32'h8001ABCD, 2, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h00008001};
        vecs[5]  = '{1'b1, 3'b000, 2'b00, 32'h301, 32'h000000A5, 32'h0,        1, 1'b0, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0};
        vecs[6]  = '{1'b1, 3'b000, 2'b01, 32'h302, 32'h00001234, 32'h0,        2, 1'b0, 32'h300, 4'b1100, 32'h12341234, 32'h0};
        vecs[7]  = '{1'b1, 3'b000, 2'b10, 32'h304, 32'hCAFEF00D, 32'h0,        1, 1'b0, 32'h304, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{1'b0, 3'b010, 2'b00, 32'h102, 32'h0,        32'h0,        1, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 3'b000, 2'b01, 32'h101, 32'h0,        32'h0,        1, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 3'b000, 2'b00, 32'h000, 32'h0,        32'h0000007F, 4, 1'b0, 32'h000, 4'b0000, 32'h0,        32'h0000007F};
        vecs[11] = '{1'b0, 3'b000, 2'b00, 32'h201, 32'h0,        32'h0000FF00, 1, 1'b0, 32'h200, 4'b0000, 32'h0,        32'hFFFFFFFF};
        vecs[12] = '{1'b0, 3'b011, 2'b00, 32'h000, 32'h0,        32'h0,        1, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 3'b000, 2'b11, 32'h000, 32'h0,        32'h0,        1, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 3'b101, 2'b00, 32'h200, 32'h0,        32'h1234F00D, 1, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h0000F00D};

        #12;
        chk("rst_valid", {31'd0, O_bus_valid}, 32'd0);
        chk("rst_stall", {31'd0, O_stall}, 32'd0);
        chk("rst_done", {31'd0, O_done}, 32'd0);
        chk("rst_rdata", O_rdata, 32'd0);
        chk("rst_addr", O_bus_addr, 32'd0);
        chk("rst_wdata", O_bus_wdata, 32'd0);
        chk("rst_strb", {28'd0, O_bus_wstrb}, 32'd0);
        @(negedge I_clk);
        I_rst = 1'b0;

        for (int i = 0; i < 15; i++) run_access(vecs[i]);

        // Timeout: ready never arrives.
        @(negedge I_clk);
        drive(vecs[0]);
        push_exp(1'b0, 32'd0, 1'b1);
        vcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge I_clk);
            I_req = 1'b0;
            if (O_done) seen = 1'b1;
            else if (O_bus_valid) vcnt++;
        end
        chk("to_done_seen", {31'd0, seen}, 32'd1);
        chk("to_valid_cycles", vcnt, 4);
        chk("to_rdata_hold", O_rdata, 32'd0);

        // Reset in the middle of a bus access.
        run_access(vecs[7]);
        @(negedge I_clk);
        drive(vecs[0]);
        @(negedge I_clk);
        I_req = 1'b0;
        chk("pre_rst_valid", {31'd0, O_bus_valid}, 32'd1);
        #2 I_rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, O_bus_valid}, 32'd0);
        chk("arst_stall", {31'd0, O_stall}, 32'd0);
        sb.delete();
        model_rdata = 32'd0;
        @(negedge I_clk);
        I_rst = 1'b0;
        run_access(vecs[1]);
        run_access(vecs[6]);

        repeat (3) @(negedge I_clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
